// File: rtl/selector_pkg.sv
// Shared constants for the crossbar port selector: control-word field layout
// and the default header-bit positions used to build the lookup key.
package selector_pkg;

  // Width of one port field inside the control word.
  localparam int PORT_WIDTH = 8;

  // Field index of each port field in the control word (field 0 is the LSBs).
  localparam int SRC_FIELD  = 3;
  localparam int DST_FIELD  = 2;
  localparam int PCIE_FIELD = 1;
  localparam int OUT_FIELD  = 0;

  // Default key: four header bit indices, packed MSB-first (first field is key MSB).
  localparam int DEFAULT_KEY_BITS = 4;
  localparam logic [16*DEFAULT_KEY_BITS-1:0] DEFAULT_KEY_POS =
    {16'd238, 16'd223, 16'd221, 16'd215};

  // Bit offset of a port field within the control word.
  function automatic int field_lsb(input int field);
    return field * PORT_WIDTH;
  endfunction

endpackage

// File: rtl/crossbar_port_selector_if.sv
// Streaming input/output bus of the port selector: parser side (datavalid/in_rdy)
// and crossbar side (out_wr/out_rdy).
interface crossbar_port_selector_if #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32
);
  logic                  datavalid;
  logic                  in_rdy;
  logic [CTRL_WIDTH-1:0] in_ctl;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_wr;
  logic                  out_rdy;
  logic [CTRL_WIDTH-1:0] out_ctl;
  logic [DATA_WIDTH-1:0] out_data;

  // Source of words / sink of results (parser + crossbar seen together).
  modport master (
    output datavalid, in_ctl, in_data, out_rdy,
    input  in_rdy, out_wr, out_ctl, out_data
  );

  // The selector itself.
  modport slave (
    input  datavalid, in_ctl, in_data, out_rdy,
    output in_rdy, out_wr, out_ctl, out_data
  );
endinterface

// File: rtl/crossbar_port_selector_port_lut.sv
// Key -> output-port table. Register based so it can be initialised on reset
// to an even spread of keys over the ports, and rewritten at runtime.
module port_lut
  import selector_pkg::*;
#(
  parameter int KEY_BITS    = 4,
  parameter int NUM_PORTS   = 4,
  parameter int ENTRY_WIDTH = PORT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [KEY_BITS-1:0]    wr_addr,
  input  logic [ENTRY_WIDTH-1:0] wr_data,
  output logic                   wr_err,
  input  logic                   rd_en,
  input  logic [KEY_BITS-1:0]    rd_addr,
  output logic [ENTRY_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 2**KEY_BITS;
  localparam logic [ENTRY_WIDTH:0] PORT_LIMIT = (ENTRY_WIDTH+1)'(NUM_PORTS);

  logic [ENTRY_WIDTH-1:0] lut_q [DEPTH];
  logic                   wr_ok;

  // Entries naming a non-existent crossbar output are refused.
  assign wr_ok = {1'b0, wr_data} < PORT_LIMIT;

  // Table init/update, read-before-write lookup and the reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this table is built from flops, not a RAM macro, so it can and must take a reset value.
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= ENTRY_WIDTH'((i * NUM_PORTS) >> KEY_BITS);
      end
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment makes a same-edge read return the old entry.
      if (rd_en) rd_data <= lut_q[rd_addr];
      if (wr_en && wr_ok) lut_q[wr_addr] <= wr_data;
      wr_err <= wr_en && !wr_ok;
    end
  end

endmodule

// File: rtl/crossbar_port_selector.sv
// Header-bit port selector in front of the crossbar: picks KEY_BITS header bits,
// looks them up in port_lut and writes the result into the low control field.
// Two-stage stallable pipeline plus saturating per-port packet counters.
module crossbar_port_selector #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int PORT_WIDTH = selector_pkg::PORT_WIDTH,
  parameter int NUM_PORTS  = 4,
  parameter int KEY_BITS   = selector_pkg::DEFAULT_KEY_BITS,
  parameter logic [16*KEY_BITS-1:0] KEY_POS = selector_pkg::DEFAULT_KEY_POS,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  crossbar_port_selector_if.slave      bus,
  input  logic                         tbl_wr,
  input  logic [KEY_BITS-1:0]          tbl_addr,
  input  logic [PORT_WIDTH-1:0]        tbl_data,
  output logic                         tbl_err,
  input  logic [$clog2(NUM_PORTS)-1:0] cnt_sel,
  output logic [CNT_WIDTH-1:0]         cnt_val
);
  localparam int SEL_WIDTH = $clog2(NUM_PORTS);
  localparam int HI_WIDTH  = CTRL_WIDTH - PORT_WIDTH;

  logic                  en;
  logic [KEY_BITS-1:0]   key;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [HI_WIDTH-1:0]   s1_ctl_hi;
  logic [KEY_BITS-1:0]   s1_key;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [HI_WIDTH-1:0]   s2_ctl_hi;
  logic [PORT_WIDTH-1:0] s2_port;
  logic                  out_fire;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_PORTS];
  logic                  unused_ctl_low;

  // The whole pipeline moves together; it only freezes while a result is refused.
  assign en          = !s2_valid || bus.out_rdy;
  assign bus.in_rdy  = en;
  assign bus.out_wr  = s2_valid;
  assign bus.out_ctl = {s2_ctl_hi, s2_port};
  assign bus.out_data = s2_data;
  assign out_fire    = s2_valid && bus.out_rdy;

  // Incoming low control field is overwritten by the looked-up port.
  assign unused_ctl_low = ^bus.in_ctl[PORT_WIDTH-1:0];

  // Key bit i comes from the i-th 16-bit field counted from the LSB end,
  // so the first field in KEY_POS lands in the key MSB.
  for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
    localparam int POS = int'(KEY_POS[16*i +: 16]);
    assign key[i] = bus.in_data[POS];
  end

  // Stage valids and the output payload (out_* must read zero after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_ctl_hi <= '0;
    end else if (en) begin
      s1_valid  <= bus.datavalid;
      s2_valid  <= s1_valid;
      s2_data   <= s1_data;
      s2_ctl_hi <= s1_ctl_hi;
    end
  end

  // Stage-1 payload; qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: payload registers without reset are safe because nothing downstream uses them while s1_valid=0.
    if (en) begin
      s1_data   <= bus.in_data;
      s1_ctl_hi <= bus.in_ctl[CTRL_WIDTH-1:PORT_WIDTH];
      s1_key    <= key;
    end
  end

  // Stage-2 port lookup; the table register is the low field of out_ctl.
  port_lut #(
    .KEY_BITS   (KEY_BITS),
    .NUM_PORTS  (NUM_PORTS),
    .ENTRY_WIDTH(PORT_WIDTH)
  ) u_port_lut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tbl_wr),
    .wr_addr(tbl_addr),
    .wr_data(tbl_data),
    .wr_err (tbl_err),
    .rd_en  (en),
    .rd_addr(s1_key),
    .rd_data(s2_port)
  );

  // Saturating per-port delivery counters and the registered counter readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      cnt_val <= '0;
    end else begin
      cnt_val <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cnt_sel == SEL_WIDTH'(p)) cnt_val <= cnt_q[p];
        if (out_fire && s2_port == PORT_WIDTH'(p) && cnt_q[p] != '1)
          cnt_q[p] <= cnt_q[p] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_crossbar_port_selector.sv
// Self-checking bench for crossbar_port_selector: directed cases with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_crossbar_port_selector;
  localparam int DW   = 480;
  localparam int CW   = 32;
  localparam int PW   = 8;
  localparam int NP   = 4;
  localparam int KB   = 4;
  localparam int CNTW = 32;
  // Header bit feeding key bit i (key bit 3 = bit 238 ... key bit 0 = bit 215).
  localparam int KEY_BIT_POS [KB] = '{215, 221, 223, 238};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tbl_wr;
  logic [KB-1:0]   tbl_addr;
  logic [PW-1:0]   tbl_data;
  logic            tbl_err;
  logic [1:0]      cnt_sel;
  logic [CNTW-1:0] cnt_val;

  always #5 clk = ~clk;

  crossbar_port_selector_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  crossbar_port_selector dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tbl_wr  (tbl_wr),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .tbl_err (tbl_err),
    .cnt_sel (cnt_sel),
    .cnt_val (cnt_val)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [KB-1:0] key_of(input logic [DW-1:0] d);
    logic [KB-1:0] k;
    for (int i = 0; i < KB; i++) k[i] = d[KEY_BIT_POS[i]];
    return k;
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [KB-1:0] k);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    for (int i = 0; i < KB; i++) d[KEY_BIT_POS[i]] = k[i];
    return d;
  endfunction

  // ---------------- reference model ----------------
  // Every accepted word needs two enabled edges to reach the output; its port is
  // taken from the table as it stood on the second of those edges (before that
  // edge's table write).
  typedef struct {
    logic [CW-1:0] ctl;
    logic [DW-1:0] data;
    logic [KB-1:0] key;
    int            port;
    int            age;
  } word_t;

  word_t           q[$];
  int              mtab [2**KB];
  logic [CNTW-1:0] mcnt [NP];
  logic            exp_err;
  logic [CNTW-1:0] exp_cnt;
  bit              model_ok = 1'b0;
  int              fire_cnt = 0;

  // Compare outputs against the model, then advance the model over the next edge.
  always @(negedge clk) begin : monitor
    logic  exp_wr;
    logic  en;
    int    p;
    word_t w;
    exp_wr = 1'b0;
    if (model_ok) begin
      exp_wr = (q.size() > 0) && (q[0].age >= 2);
      check("out_wr", bus.out_wr, exp_wr);
      if (exp_wr) begin
        check("out_ctl", bus.out_ctl, {q[0].ctl[CW-1:PW], PW'(q[0].port)});
        check("out_data", bus.out_data, q[0].data);
      end
      check("in_rdy", bus.in_rdy, !exp_wr || bus.out_rdy);
      check("tbl_err", tbl_err, exp_err);
      check("cnt_val", cnt_val, exp_cnt);
    end
    if (rst) begin
      q.delete();
      for (int i = 0; i < 2**KB; i++) mtab[i] = (i * NP) / (2**KB);
      for (int i = 0; i < NP; i++) mcnt[i] = '0;
      exp_err  = 1'b0;
      exp_cnt  = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      en = !exp_wr || bus.out_rdy;
      exp_cnt = (int'(cnt_sel) < NP) ? mcnt[cnt_sel] : '0;
      if (exp_wr && bus.out_rdy) begin
        p = q[0].port;
        if (mcnt[p] != '1) mcnt[p] = mcnt[p] + 1;
        void'(q.pop_front());
        fire_cnt++;
      end
      if (en) begin
        foreach (q[i]) begin
          if (q[i].age == 1) q[i].port = mtab[q[i].key];
          q[i].age++;
        end
        if (bus.datavalid) begin
          w.ctl  = bus.in_ctl;
          w.data = bus.in_data;
          w.key  = key_of(bus.in_data);
          w.port = -1;
          w.age  = 1;
          q.push_back(w);
        end
      end
      exp_err = tbl_wr && (int'(tbl_data) >= NP);
      if (tbl_wr && int'(tbl_data) < NP) mtab[tbl_addr] = int'(tbl_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [KB-1:0] k, input logic [CW-1:0] ctl, output logic [DW-1:0] d);
    int n = 0;
    d = mk_data(k);
    bus.datavalid = 1'b1;
    bus.in_ctl    = ctl;
    bus.in_data   = d;
    while (!bus.in_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_rdy) check("send_timeout", bus.in_rdy, 1'b1);
    tick();
    bus.datavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bound on total run time in case the design wedges.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int  idx, base;
    bit  new_word, acc;

    bus.datavalid = 1'b0;
    bus.in_ctl    = '0;
    bus.in_data   = '0;
    bus.out_rdy   = 1'b1;
    tbl_wr        = 1'b0;
    tbl_addr      = '0;
    tbl_data      = '0;
    cnt_sel       = '0;

    // Reset state.
    tick();
    tick();
    check("rst_out_wr", bus.out_wr, 1'b0);
    check("rst_out_ctl", bus.out_ctl, 32'h0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_tbl_err", tbl_err, 1'b0);
    check("rst_cnt_val", cnt_val, 32'h0);
    rst = 1'b0;

    // Case 1: key 0xB with default table -> port 2, two-edge latency.
    send(4'hB, 32'hAABBCC77, d);
    check("t1_not_yet", bus.out_wr, 1'b0);
    tick();
    check("t1_out_wr", bus.out_wr, 1'b1);
    check("t1_out_ctl", bus.out_ctl, 32'hAABBCC02);
    check("t1_out_data", bus.out_data, d);
    tick();

    // Case 2: reprogram entry B to 3, then try an illegal port 5.
    tbl_wr = 1'b1; tbl_addr = 4'hB; tbl_data = 8'd3;
    tick();
    tbl_wr = 1'b0;
    check("t2_no_err", tbl_err, 1'b0);
    send(4'hB, 32'hAABBCC77, d);
    tick();
    check("t2_new_port", bus.out_ctl, 32'hAABBCC03);
    tick();
    tbl_wr = 1'b1; tbl_addr = 4'hB; tbl_data = 8'h05;
    tick();
    tbl_wr = 1'b0;
    check("t2_err_pulse", tbl_err, 1'b1);
    tick();
    check("t2_err_clear", tbl_err, 1'b0);
    send(4'hB, 32'hAABBCC77, d);
    tick();
    check("t2_entry_kept", bus.out_ctl, 32'hAABBCC03);
    tick();

    // Case 3: 8 back-to-back words with out_rdy low in cycles 3-5.
    base = fire_cnt;
    idx = 0;
    new_word = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.out_rdy = !(c >= 3 && c <= 5);
      if (idx < 8) begin
        if (new_word) begin
          bus.in_data = mk_data(4'($urandom));
          bus.in_ctl  = $urandom;
          new_word    = 1'b0;
        end
        bus.datavalid = 1'b1;
      end else begin
        bus.datavalid = 1'b0;
      end
      #1;
      if (c >= 3 && c <= 5) check("t3_in_rdy_hold", bus.in_rdy, 1'b0);
      acc = bus.datavalid && bus.in_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        new_word = 1'b1;
      end
    end
    bus.datavalid = 1'b0;
    bus.out_rdy   = 1'b1;
    check("t3_all_emitted", 32'(fire_cnt - base), 32'd8);

    // Case 4: table write on the edge a key-5 word moves into stage 2.
    bus.datavalid = 1'b1;
    bus.in_data   = mk_data(4'd5);
    bus.in_ctl    = 32'h11223300;
    tick();
    bus.in_data   = mk_data(4'd5);
    bus.in_ctl    = 32'h44556600;
    tbl_wr = 1'b1; tbl_addr = 4'd5; tbl_data = 8'd2;
    tick();
    bus.datavalid = 1'b0;
    tbl_wr = 1'b0;
    check("t4_old_port", bus.out_ctl, 32'h11223301);
    tick();
    check("t4_new_port", bus.out_ctl, 32'h44556602);
    tick();

    // Case 5: counters, then reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 3; i++) send(4'd4, 32'h01000000, d);
    for (int i = 0; i < 2; i++) send(4'd12, 32'h03000000, d);
    for (int i = 0; i < 4; i++) tick();
    cnt_sel = 2'd1;
    tick();
    check("t5_cnt1", cnt_val, 32'd3);
    cnt_sel = 2'd3;
    tick();
    check("t5_cnt3", cnt_val, 32'd2);
    cnt_sel = 2'd0;
    tick();
    check("t5_cnt0", cnt_val, 32'd0);
    cnt_sel = 2'd1;
    bus.datavalid = 1'b1;
    bus.in_data   = mk_data(4'd4);
    tick();
    bus.in_data   = mk_data(4'd4);
    tick();
    check("t5_busy", bus.out_wr, 1'b1);
    rst = 1'b1;
    bus.datavalid = 1'b0;
    tick();
    check("t5_rst_drop", bus.out_wr, 1'b0);
    check("t5_rst_cnt_val", cnt_val, 32'd0);
    rst = 1'b0;
    tick();
    check("t5_cnt1_cleared", cnt_val, 32'd0);
    send(4'hB, 32'hAABBCC77, d);
    tick();
    check("t5_table_default", bus.out_ctl, 32'hAABBCC02);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.datavalid = 1'($urandom_range(1));
      bus.in_data   = mk_data(4'($urandom));
      bus.in_ctl    = $urandom;
      bus.out_rdy   = ($urandom_range(3) != 0);
      tbl_wr        = ($urandom_range(7) == 0);
      tbl_addr      = 4'($urandom);
      tbl_data      = PW'($urandom_range(5));
      cnt_sel       = 2'($urandom);
      rst           = ($urandom_range(299) == 0);
      tick();
    end
    bus.datavalid = 1'b0;
    bus.out_rdy   = 1'b1;
    tbl_wr        = 1'b0;
    rst           = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("drain_empty", bus.out_wr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
